// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and saturation helper for the iterative CORDIC sequencer.
package cordic_pkg;

  localparam logic [15:0] HALF_PI   = 16'h4000;
  localparam logic [15:0] GAIN_COMP = 16'h4DBA;

  // atan(2^-i) scaled so that 0x8000 is pi.
  localparam logic [15:0] ATAN_TABLE [16] = '{
    16'h2000, 16'h12E4, 16'h09FB, 16'h0511, 16'h028B, 16'h0145, 16'h00A2, 16'h0051,
    16'h0028, 16'h0014, 16'h000A, 16'h0005, 16'h0002, 16'h0001, 16'h0000, 16'h0000
  };

  typedef enum logic [1:0] {
    StIdle,
    StRotate,
    StDone
  } state_e;

  // Clamp a sign-extended value to the signed range of a width-bit word.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] value,
                                                 input int unsigned width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end
    if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/cordic_microrotation.sv
// Single shift-add CORDIC micro-rotation; the sequencer reuses it every iteration.
module cordic_microrotation
  import cordic_pkg::*;
#(
  parameter int unsigned IntWidth = 18
) (
  input  logic signed [IntWidth-1:0] x_i,
  input  logic signed [IntWidth-1:0] y_i,
  input  logic signed [15:0]         z_i,
  input  logic        [3:0]          iter_i,
  output logic signed [IntWidth-1:0] x_o,
  output logic signed [IntWidth-1:0] y_o,
  output logic signed [15:0]         z_o
);

  logic signed [IntWidth-1:0] x_shift;
  logic signed [IntWidth-1:0] y_shift;
  logic signed [15:0]         atan;

  // Rotate toward zero residual angle; both shifts use the pre-update operands.
  always_comb begin
    x_shift = x_i >>> iter_i;
    y_shift = y_i >>> iter_i;
    atan    = signed'(ATAN_TABLE[iter_i]);
    if (!z_i[15]) begin
      x_o = x_i - y_shift;
      y_o = y_i + x_shift;
      z_o = z_i - atan;
    end else begin
      x_o = x_i + y_shift;
      y_o = y_i - x_shift;
      z_o = z_i + atan;
    end
  end

endmodule

// File: rtl/cordic_rotation_sequencer.sv
// Iterative CORDIC rotation controller: accept a job, pre-rotate by quadrant, run
// cordic_steps micro-rotations on one shared unit, then hold the result until taken.
module cordic_rotation_sequencer
  import cordic_pkg::*;
#(
  parameter int unsigned data_width   = 16,
  parameter int unsigned angle_width  = 16,
  parameter int unsigned cordic_steps = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [data_width-1:0]  x_in,
  input  logic [data_width-1:0]  y_in,
  input  logic [angle_width-1:0] angle_in,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [data_width-1:0]  x_out,
  output logic [data_width-1:0]  y_out,
  output logic [angle_width-1:0] z_out,
  output logic                   busy
);

  // Two guard bits absorb the CORDIC gain and the negation of -2^(data_width-1).
  localparam int unsigned IntWidth = data_width + 2;
  localparam logic [3:0]  LastIter = 4'(cordic_steps - 1);

  state_e                     state_q, state_d;
  logic [3:0]                 iter_q, iter_d;
  logic signed [IntWidth-1:0] x_q, x_d, y_q, y_d;
  logic signed [IntWidth-1:0] x_ext, y_ext, x_pre, y_pre, x_nxt, y_nxt;
  logic [angle_width-1:0]     z_q, z_d, z_pre;
  logic signed [15:0]         z_nxt;

  cordic_microrotation #(
    .IntWidth (IntWidth)
  ) u_micro (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (signed'(z_q)),
    .iter_i (iter_q),
    .x_o    (x_nxt),
    .y_o    (y_nxt),
    .z_o    (z_nxt)
  );

  // Quadrant pre-rotation so the remaining angle lies within the CORDIC convergence range.
  always_comb begin
    x_ext = IntWidth'(signed'(x_in));
    y_ext = IntWidth'(signed'(y_in));
    if ($signed(angle_in) > $signed(HALF_PI)) begin
      x_pre = -y_ext;
      y_pre = x_ext;
      z_pre = angle_in - HALF_PI;
    end else if ($signed(angle_in) < -$signed(HALF_PI)) begin
      x_pre = y_ext;
      y_pre = -x_ext;
      z_pre = angle_in + HALF_PI;
    end else begin
      x_pre = x_ext;
      y_pre = y_ext;
      z_pre = angle_in;
    end
  end

  // Next-state logic; flush overrides every transition, including a same-cycle accept.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StRotate;
          iter_d  = 4'd0;
          x_d     = x_pre;
          y_d     = y_pre;
          z_d     = z_pre;
        end
      end
      StRotate: begin
        x_d = x_nxt;
        y_d = y_nxt;
        z_d = z_nxt;
        if (iter_q == LastIter) begin
          state_d = StDone;
        end else begin
          iter_d = iter_q + 4'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      iter_d  = 4'd0;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      iter_q  <= 4'd0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  // Handshake flags decode the state register only; results saturate to the port width.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    x_out     = data_width'(saturate(32'(x_q), data_width));
    y_out     = data_width'(saturate(32'(y_q), data_width));
    z_out     = z_q;
  end

endmodule

// File: tb/tb_cordic_rotation_sequencer.sv
// Directed bench for cordic_rotation_sequencer: vector table plus handshake, flush and reset sequences.
module tb_cordic_rotation_sequencer;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [15:0] x_in, y_in, angle_in, x_out, y_out, z_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] a;
    int          ex;
    int          ey;
    int          tol;
  } vec_t;

  vec_t vecs [10];

  cordic_rotation_sequencer #(
    .data_width   (16),
    .angle_width  (16),
    .cordic_steps (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .angle_in  (angle_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    checks++;
    if ((act - exp > tol) || (exp - act > tol)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic start_job(input logic [15:0] x, input logic [15:0] y, input logic [15:0] a);
    x_in     = x;
    y_in     = y;
    angle_in = a;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check_eq({name, "_out_valid_timeout"}, int'(seen), 1);
  endtask

  task automatic check_result(input string name, input int ex, input int ey, input int tol);
    check_near({name, "_x"}, int'($signed(x_out)), ex, tol);
    check_near({name, "_y"}, int'($signed(y_out)), ey, tol);
    check_near({name, "_z"}, int'($signed(z_out)), 0, 2);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] hx, hy, hz;
    bit          early, stable, ready_seen, valid_seen;

    // x, y, angle, expected x, expected y, tolerance (0x4DBA * gain ~= 0x7FFF)
    vecs[0] = '{16'h4DBA, 16'h0000, 16'h2000,  23170,  23170, 10};
    vecs[1] = '{16'h4DBA, 16'h0000, 16'h6000, -23170,  23170, 10};
    vecs[2] = '{16'h4DBA, 16'h0000, 16'h8000, -32767,      0, 10};
    vecs[3] = '{16'h4DBA, 16'h0000, 16'h0000,  32767,      0, 10};
    vecs[4] = '{16'h4DBA, 16'h0000, 16'hE000,  23170, -23170, 10};
    vecs[5] = '{16'h4DBA, 16'h0000, 16'hA000, -23170, -23170, 10};
    vecs[6] = '{16'h2000, 16'h0000, 16'h4000,      0,  13490, 10};
    vecs[7] = '{16'h0000, 16'h2000, 16'hC000,  13490,      0, 10};
    vecs[8] = '{16'h7FFF, 16'h7FFF, 16'h0000,  32767,  32767,  0};
    vecs[9] = '{16'h8000, 16'h8000, 16'h0000, -32768, -32768,  0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    angle_in  = '0;
    step();
    step();
    check_eq("reset_in_ready", int'(in_ready), 1);
    check_eq("reset_out_valid", int'(out_valid), 0);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_x_out", int'(x_out), 0);
    check_eq("reset_y_out", int'(y_out), 0);
    check_eq("reset_z_out", int'(z_out), 0);
    reset = 1'b0;
    step();

    // Table: each job checks the exact 16-cycle latency and the rotated result.
    for (int i = 0; i < 10; i++) begin
      start_job(vecs[i].x, vecs[i].y, vecs[i].a);
      early = 1'b0;
      for (int k = 1; k < 16; k++) begin
        step();
        if (out_valid) early = 1'b1;
      end
      check_eq($sformatf("vec%0d_early_valid", i), int'(early), 0);
      step();
      check_eq($sformatf("vec%0d_valid_at_16", i), int'(out_valid), 1);
      check_result($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].tol);
      take_result();
      check_eq($sformatf("vec%0d_ready_after_take", i), int'(in_ready), 1);
    end

    // Backpressure: result held for 40 cycles, second job refused until released.
    start_job(vecs[0].x, vecs[0].y, vecs[0].a);
    wait_out("bp");
    hx = x_out;
    hy = y_out;
    hz = z_out;
    x_in       = vecs[1].x;
    y_in       = vecs[1].y;
    angle_in   = vecs[1].a;
    in_valid   = 1'b1;
    stable     = 1'b1;
    ready_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (x_out !== hx || y_out !== hy || z_out !== hz || out_valid !== 1'b1) stable = 1'b0;
      if (in_ready) ready_seen = 1'b1;
    end
    check_eq("bp_outputs_stable", int'(stable), 1);
    check_eq("bp_in_ready_seen", int'(ready_seen), 0);
    take_result();
    check_eq("bp_release_out_valid", int'(out_valid), 0);
    check_eq("bp_release_in_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check_eq("bp_second_accepted", int'(busy), 1);
    wait_out("bp2");
    check_result("bp2", vecs[1].ex, vecs[1].ey, vecs[1].tol);
    take_result();

    // Flush mid-job: back to idle next edge and no result ever appears.
    start_job(vecs[4].x, vecs[4].y, vecs[4].a);
    repeat (7) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_in_ready", int'(in_ready), 1);
    check_eq("flush_busy", int'(busy), 0);
    valid_seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (out_valid) valid_seen = 1'b1;
      step();
    end
    check_eq("flush_no_out_valid", int'(valid_seen), 0);
    // Flush beats a coincident offer in idle.
    x_in     = vecs[6].x;
    y_in     = vecs[6].y;
    angle_in = vecs[6].a;
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    check_eq("flush_beats_accept", int'(busy), 0);
    start_job(vecs[6].x, vecs[6].y, vecs[6].a);
    wait_out("post_flush");
    check_result("post_flush", vecs[6].ex, vecs[6].ey, vecs[6].tol);
    take_result();

    // Reset mid-job with an offer held: reset values, then accept right after release.
    start_job(vecs[5].x, vecs[5].y, vecs[5].a);
    repeat (10) step();
    reset    = 1'b1;
    flush    = 1'b1;
    x_in     = vecs[7].x;
    y_in     = vecs[7].y;
    angle_in = vecs[7].a;
    in_valid = 1'b1;
    step();
    flush = 1'b0;
    check_eq("midreset_in_ready", int'(in_ready), 1);
    check_eq("midreset_out_valid", int'(out_valid), 0);
    check_eq("midreset_busy", int'(busy), 0);
    check_eq("midreset_x_out", int'(x_out), 0);
    check_eq("midreset_y_out", int'(y_out), 0);
    check_eq("midreset_z_out", int'(z_out), 0);
    reset = 1'b0;
    step();
    in_valid = 1'b0;
    check_eq("midreset_accept_next", int'(busy), 1);
    wait_out("post_reset");
    check_result("post_reset", vecs[7].ex, vecs[7].ey, vecs[7].tol);
    take_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_rotation_sequencer.md
# cordic_rotation_sequencer

Iterative controller for the CORDIC rotation datapath: accepts one (x, y, target angle) job through a valid/ready handshake, applies quadrant pre-rotation, then time-multiplexes a single shift-add micro-rotation unit over `cordic_steps` iterations. It replaces the unrolled stage chain where area matters, and emits the rotated vector through a valid/ready output port with backpressure.

## Interface
Parameters:
- `data_width`, 16: signed width of x/y in and out (Q1.(data_width-1))
- `angle_width`, 16: signed angle width; fixed at 16, where 0x8000 = -pi and 0x2000 = pi/4
- `cordic_steps`, 16: iteration count, 1..16

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  job offered
- `in_ready`  out  1  sequencer can accept a job
- `x_in`, `y_in`  in  data_width  signed input vector
- `angle_in`  in  angle_width  signed target rotation angle
- `flush`  in  1  synchronous abort of the current job
- `out_valid`  out  1  result held
- `out_ready`  in  1  consumer accepts the result
- `x_out`, `y_out`  out  data_width  signed rotated vector, saturated
- `z_out`  out  angle_width  signed residual angle after the last iteration
- `busy`  out  1  high in ROTATE or DONE

## Operation
- FSM states: IDLE, ROTATE, DONE.
- IDLE: `in_ready`=1. On `in_valid`&`in_ready`, capture the job with pre-rotation and go to ROTATE with iteration counter i=0.
- Pre-rotation, applied at capture:
  - angle > 0x4000: x=-y_in, y=x_in, z=angle-0x4000.
  - angle < -0x4000 (signed): x=y_in, y=-x_in, z=angle+0x4000.
  - Otherwise: x=x_in, y=y_in, z=angle.
- ROTATE: one micro-rotation per cycle.
  - z>=0: x-=y>>>i, y+=x>>>i, z-=atan[i].
  - z<0: x+=y>>>i, y-=x>>>i, z+=atan[i].
  - x and y updates use the pre-update values of both operands.
  - When i==cordic_steps-1, go to DONE. Otherwise i+=1.
- DONE: `out_valid`=1 and outputs stable. On `out_ready`, return to IDLE.
- Arithmetic:
  - Internal x/y registers are data_width+2 bits (sign-extended inputs; covers CORDIC gain 1.647 plus pre-rotation negation).
  - Shifts are arithmetic.
  - `x_out`/`y_out` saturate the internal value to [-2^(data_width-1), 2^(data_width-1)-1].
  - z is angle_width bits with wrap-around arithmetic.
- Gain is not compensated; callers pre-scale by 0.60725 (0x4DBA at 16 bits).
- `flush`: from any state, return to IDLE next edge, drop the job, `out_valid`=0. If `flush` and `in_valid` coincide in IDLE, `flush` wins and nothing is captured.
- atan table (i=0..15): 0x2000, 0x12E4, 0x09FB, 0x0511, 0x028B, 0x0145, 0x00A2, 0x0051, 0x0028, 0x0014, 0x000A, 0x0005, 0x0002, 0x0001, 0x0000, 0x0000.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `x_out`=`y_out`=`z_out`=0, i=0.
- A reset mid-job discards the job; reset overrides `flush`.
- Acceptance edge E0. Iterations occur on edges E1..E(cordic_steps). `out_valid` is high from the cycle after E(cordic_steps), i.e. latency = cordic_steps cycles from acceptance.
- Output handshake: the edge with `out_valid`&`out_ready` returns to IDLE. `in_ready` rises the following cycle. There is no accept in DONE.
- Minimum issue interval: cordic_steps+2 cycles.
- `in_ready` and `out_valid` are registered-state decodes with no combinational path from `in_valid`/`out_ready`.
- Outputs are held unchanged while `out_valid`=1 and `out_ready`=0, indefinitely.

## Structure
- Package `cordic_pkg`:
  - atan ROM constant array
  - FSM state enum
  - constants HALF_PI=0x4000 and GAIN_COMP=0x4DBA
  - saturate function
- Sub-module `cordic_microrotation`: combinational; inputs x, y, z, i; outputs next x, y, z. It owns the atan lookup.
- The top level holds the FSM, counter, registers, pre-rotation and saturation.

## Test plan
- Reset, then x_in=0x4DBA, y_in=0, angle=0x2000 → after 16 cycles `out_valid`; x_out≈y_out≈0x5A82 (±8 LSB); |z_out|≤2.
- angle=0x6000 (3pi/4), x_in=0x4DBA → pre-rotation +pi/2; x_out≈-0x5A82, y_out≈0x5A82.
- angle=0x8000 (-pi), x_in=0x4DBA → x_out≈-0x7FFF (saturated at 0x8000 allowed), |y_out|≤8.
- Hold out_ready=0 for 40 cycles after `out_valid` → outputs stable, `in_ready`=0, and a second `in_valid` is not accepted; release → IDLE, then the second job is accepted the next cycle.
- Assert `flush` at iteration 7 → IDLE next cycle, `out_valid` never rises; a new job then completes with correct values.
- Assert `reset` at iteration 10 with in_valid held high → all outputs return to reset values; the job is accepted the first cycle after reset deasserts.
